// File: rtl/asip_pkg.sv
// rtl/asip_pkg.sv - shared types, field positions and helpers for the multicycle ASIP
package asip_pkg;

  localparam int INST_W = 24;
  localparam int OP_LSB = 20;
  localparam int RD_LSB = 16;
  localparam int RN_LSB = 12;
  localparam int RM_LSB = 8;
  localparam int IMM_W  = 12;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_ADDI = 4'h4, OP_SUBI = 4'h5, OP_ANDI = 4'h6, OP_ORI  = 4'h7,
    OP_LDR  = 4'h8, OP_STR  = 4'h9, OP_BEQ  = 4'hA, OP_JMP  = 4'hB,
    OP_NOP  = 4'hC, OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_e;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/asip_mc_if.sv
// rtl/asip_mc_if.sv - instruction and data memory req/ack bus of the multicycle ASIP
interface asip_mc_if #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 24
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [23:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [PC_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/asip_regfile.sv
// rtl/asip_regfile.sv - register file with three combinational reads and one write port
module asip_regfile #(
  parameter int DATA_W = 24,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rn_i,
  input  logic [3:0]        rm_i,
  input  logic [3:0]        rd_i,
  output logic [DATA_W-1:0] rn_data_o,
  output logic [DATA_W-1:0] rm_data_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [3:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DATA_W-1:0] rf_q [NREG];

  // Register fields are 4 bits wide; smaller files alias indices modulo NREG.
  function automatic logic [AW-1:0] wrap(input logic [3:0] a);
    return AW'(32'(a) % NREG);
  endfunction

  assign rn_data_o = rf_q[wrap(rn_i)];
  assign rm_data_o = rf_q[wrap(rm_i)];
  assign rd_data_o = rf_q[wrap(rd_i)];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we_i && wrap(wa_i) != '0) begin
      rf_q[wrap(wa_i)] <= wd_i;
    end
  end
endmodule

// File: rtl/asip_mc.sv
// rtl/asip_mc.sv - multicycle 24-bit-instruction ASIP core with handshaked memories
module asip_mc
  import asip_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int PC_W   = 16,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  asip_mc_if.master         bus,
  output logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] aluRes,
  output logic              halted
);
  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] opn_q, opn_d, op2_q, op2_d, opd_q, opd_d;
  logic [DATA_W-1:0] alu_q, alu_d, ld_q, ld_d;
  logic [DATA_W-1:0] rn_data, rm_data, rd_data, alu_res, wb_data;
  logic [3:0]        op_raw;
  logic [11:0]       imm12;
  op_e               op;
  alu_op_e           alu_op;
  logic              rf_we;

  assign op_raw  = inst_q[OP_LSB +: 4];
  assign op      = op_e'(op_raw);
  assign imm12   = inst_q[IMM_W-1:0];
  assign pc_inc  = pc_q + PC_W'(1);
  assign wb_data = (op == OP_LDR) ? ld_q : alu_q;

  asip_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .rn_i      (inst_q[RN_LSB +: 4]),
    .rm_i      (inst_q[RM_LSB +: 4]),
    .rd_i      (inst_q[RD_LSB +: 4]),
    .rn_data_o (rn_data),
    .rm_data_o (rm_data),
    .rd_data_o (rd_data),
    .we_i      (rf_we),
    .wa_i      (inst_q[RD_LSB +: 4]),
    .wd_i      (wb_data)
  );

  // Loads and stores reuse the adder for rn + sext(imm12).
  always_comb begin
    alu_op = op_raw[3] ? ALU_ADD : alu_op_e'(op_raw[1:0]);
    case (alu_op)
      ALU_SUB: alu_res = opn_q - op2_q;
      ALU_AND: alu_res = opn_q & op2_q;
      ALU_OR:  alu_res = opn_q | op2_q;
      default: alu_res = opn_q + op2_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    opn_d   = opn_q;
    op2_d   = op2_q;
    opd_d   = opd_q;
    alu_d   = alu_q;
    ld_d    = ld_q;
    rf_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opn_d = rn_data;
        opd_d = rd_data;
        if (op_raw[3:2] == 2'b00)      op2_d = rm_data;
        else if (op_raw[3:2] == 2'b01) op2_d = DATA_W'(imm12);
        else                           op2_d = DATA_W'(sext12(imm12));
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_d = S_WB;
          OP_LDR, OP_STR:                    state_d = S_MEM;
          OP_BEQ: begin
            pc_d    = (opd_q == opn_q) ? pc_inc + PC_W'(sext12(imm12)) : pc_inc;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = PC_W'(inst_q[15:0]);
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (op == OP_STR) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            ld_d    = bus.dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      inst_q  <= '0;
      opn_q   <= '0;
      op2_q   <= '0;
      opd_q   <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      opn_q   <= opn_d;
      op2_q   <= op2_d;
      opd_q   <= opd_d;
      alu_q   <= alu_d;
      ld_q    <= ld_d;
    end
  end

  // Requests are gated by reset so they fall the moment reset asserts.
  assign bus.imem_req   = rst && (state_q == S_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = rst && (state_q == S_MEM);
  assign bus.dmem_we    = (op == OP_STR);
  assign bus.dmem_addr  = PC_W'(alu_q);
  assign bus.dmem_wdata = opd_q;

  assign PC     = pc_q;
  assign aluRes = alu_q;
  assign halted = (state_q == S_HALT);
endmodule
